// File: rtl/button_param_ctrl.sv
// button_param_ctrl: turns debounced, active-low push buttons into saturating
// up/down edits of a single run-time parameter. It supports hold-to-repeat
// auto-stepping and a coarse/fine step toggle on the mode button.
module button_param_ctrl #(
    parameter int WIDTH         = 8,
    parameter int INIT_VAL      = 128,
    parameter int MIN_VAL       = 0,
    parameter int MAX_VAL       = 255,
    parameter int STEP_FINE     = 1,
    parameter int STEP_COARSE   = 16,
    parameter int HOLD_DELAY    = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_btn_up,
    input  logic             i_btn_down,
    input  logic             i_btn_mode,
    output logic [WIDTH-1:0] o_value,
    output logic             o_coarse,
    output logic             o_update,
    output logic             o_at_min,
    output logic             o_at_max
);

    localparam int CNT_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_PERIOD - 1);

    // Step arithmetic runs one bit wider than the value so sums cannot wrap.
    localparam logic [WIDTH:0]   MIN_EXT   = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH:0]   MAX_EXT   = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   STEP_F    = (WIDTH+1)'(STEP_FINE);
    localparam logic [WIDTH:0]   STEP_C    = (WIDTH+1)'(STEP_COARSE);
    localparam logic [WIDTH-1:0] MIN_V     = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_V     = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] INIT_V    = WIDTH'(INIT_VAL);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HOLD_UP = 3'd1,
        HOLD_DN = 3'd2,
        RPT_UP  = 3'd3,
        RPT_DN  = 3'd4,
        LOCK    = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic             prev_up;
    logic             prev_dn;
    logic             prev_mode;
    logic             press_up;
    logic             press_dn;
    logic             press_mode;

    logic             step_up;
    logic             step_dn;
    logic [WIDTH:0]   step_mag;
    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] value_nxt;
    logic             coarse;
    logic             update;

    // Add a step and clamp the result to the upper bound.
    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] v,
                                                 input logic [WIDTH:0]   s);
        logic [WIDTH:0] sum;
        sum = {1'b0, v} + s;
        if (sum > MAX_EXT) begin
            return MAX_V;
        end
        if (sum < MIN_EXT) begin
            return MIN_V;
        end
        return sum[WIDTH-1:0];
    endfunction

    // Subtract a step and clamp the result to the lower bound; the compare
    // is done before subtracting so the difference can never go negative.
    function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] v,
                                                 input logic [WIDTH:0]   s);
        logic [WIDTH:0] diff;
        if ({1'b0, v} < (MIN_EXT + s)) begin
            return MIN_V;
        end
        diff = {1'b0, v} - s;
        if (diff > MAX_EXT) begin
            return MAX_V;
        end
        return diff[WIDTH-1:0];
    endfunction

    assign press_up   = prev_up   & ~i_btn_up;
    assign press_dn   = prev_dn   & ~i_btn_down;
    assign press_mode = prev_mode & ~i_btn_mode;

    // Next-state, counter and step-request logic for the up/down sequencer.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        step_up   = 1'b0;
        step_dn   = 1'b0;
        if (!i_enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nxt = '0;
                    if (!i_btn_up && !i_btn_down) begin
                        state_nxt = LOCK;
                    end else if (press_up && i_btn_down) begin
                        step_up   = 1'b1;
                        state_nxt = HOLD_UP;
                    end else if (press_dn && i_btn_up) begin
                        step_dn   = 1'b1;
                        state_nxt = HOLD_DN;
                    end
                end
                HOLD_UP, RPT_UP: begin
                    // Release wins over a terminal count in the same cycle.
                    if (i_btn_up) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (!i_btn_down) begin
                        state_nxt = LOCK;
                        cnt_nxt   = '0;
                    end else if (cnt == ((state == HOLD_UP) ? HOLD_LAST : RPT_LAST)) begin
                        step_up   = 1'b1;
                        state_nxt = RPT_UP;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                HOLD_DN, RPT_DN: begin
                    if (i_btn_down) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (!i_btn_up) begin
                        state_nxt = LOCK;
                        cnt_nxt   = '0;
                    end else if (cnt == ((state == HOLD_DN) ? HOLD_LAST : RPT_LAST)) begin
                        step_dn   = 1'b1;
                        state_nxt = RPT_DN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                LOCK: begin
                    cnt_nxt = '0;
                    if (i_btn_up && i_btn_down) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Step size uses the registered mode, so a simultaneous mode press
    // only affects later steps.
    always_comb begin
        step_mag  = coarse ? STEP_C : STEP_F;
        value_nxt = value;
        if (step_up) begin
            value_nxt = sat_add(value, step_mag);
        end else if (step_dn) begin
            value_nxt = sat_sub(value, step_mag);
        end
    end

    // Sequencer state and hold/repeat counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Previous button samples; they keep tracking while disabled so that
    // presses begun during disable never fire later.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prev_up   <= 1'b1;
            prev_dn   <= 1'b1;
            prev_mode <= 1'b1;
        end else begin
            prev_up   <= i_btn_up;
            prev_dn   <= i_btn_down;
            prev_mode <= i_btn_mode;
        end
    end

    // Parameter value, step mode and change pulse.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            value  <= INIT_V;
            coarse <= 1'b0;
            update <= 1'b0;
        end else begin
            value  <= value_nxt;
            update <= (value_nxt != value);
            if (i_enable && press_mode) begin
                coarse <= ~coarse;
            end
        end
    end

    assign o_value  = value;
    assign o_coarse = coarse;
    assign o_update = update;
    assign o_at_min = (value == MIN_V);
    assign o_at_max = (value == MAX_V);

endmodule

// File: tb/tb_button_param_ctrl.sv
// Directed bench for button_param_ctrl with short hold/repeat timing.
// A second instance starts near the upper bound for saturation steps.
module tb_button_param_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       dn;
    logic       mode;
    logic [7:0] value;
    logic       coarse;
    logic       update;
    logic       at_min;
    logic       at_max;

    logic       up2;
    logic       dn2;
    logic       mode2;
    logic [7:0] value2;
    logic       coarse2;
    logic       update2;
    logic       at_min2;
    logic       at_max2;

    int total = 0;
    int bad   = 0;
    int upd_total = 0;
    int u0;

    button_param_ctrl #(
        .HOLD_DELAY    (10),
        .REPEAT_PERIOD (4)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_enable   (en),
        .i_btn_up   (up),
        .i_btn_down (dn),
        .i_btn_mode (mode),
        .o_value    (value),
        .o_coarse   (coarse),
        .o_update   (update),
        .o_at_min   (at_min),
        .o_at_max   (at_max)
    );

    button_param_ctrl #(
        .INIT_VAL      (250),
        .HOLD_DELAY    (10),
        .REPEAT_PERIOD (4)
    ) dut2 (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_enable   (en),
        .i_btn_up   (up2),
        .i_btn_down (dn2),
        .i_btn_mode (mode2),
        .o_value    (value2),
        .o_coarse   (coarse2),
        .o_update   (update2),
        .o_at_min   (at_min2),
        .o_at_max   (at_max2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count update pulses of the main instance on the falling edge.
    always @(negedge clk) begin
        if (update === 1'b1) upd_total <= upd_total + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; up = 1'b1; dn = 1'b1; mode = 1'b1;
        up2 = 1'b1; dn2 = 1'b1; mode2 = 1'b1;
        tick(2);
        rst = 1'b0;

        // Reset state
        chk("rst_value",   32'(value),   32'd128);
        chk("rst_coarse",  32'(coarse),  32'd0);
        chk("rst_update",  32'(update),  32'd0);
        chk("rst_at_min",  32'(at_min),  32'd0);
        chk("rst_at_max",  32'(at_max),  32'd0);
        chk("rst_value2",  32'(value2),  32'd250);
        chk("rst_coarse2", 32'(coarse2), 32'd0);
        chk("rst_at_min2", 32'(at_min2), 32'd0);

        // 1: single 3-cycle up press
        u0 = upd_total;
        up = 1'b0;
        tick(1);
        chk("t1_step",   32'(value),  32'd129);
        chk("t1_pulse",  32'(update), 32'd1);
        tick(2);
        up = 1'b1;
        tick(1);
        chk("t1_rel",    32'(value),  32'd129);
        chk("t1_nopul",  32'(update), 32'd0);
        tick(15);
        chk("t1_stable", 32'(value),  32'd129);
        chk("t1_pulses", 32'(upd_total - u0), 32'd1);

        // 2: up held 30 cycles -> steps at E0, E10, E14, E18, E22, E26
        do_reset();
        u0 = upd_total;
        up = 1'b0;
        tick(1);  chk("t2_e0",  32'(value), 32'd129);
        tick(9);  chk("t2_e9",  32'(value), 32'd129);
        tick(1);  chk("t2_e10", 32'(value), 32'd130);
        tick(4);  chk("t2_e14", 32'(value), 32'd131);
        tick(4);  chk("t2_e18", 32'(value), 32'd132);
        tick(4);  chk("t2_e22", 32'(value), 32'd133);
        tick(4);  chk("t2_e26", 32'(value), 32'd134);
        tick(3);
        up = 1'b1;
        tick(1);  chk("t2_e30", 32'(value), 32'd134);
        tick(5);  chk("t2_end", 32'(value), 32'd134);
        chk("t2_pulses", 32'(upd_total - u0), 32'd6);

        // 3a: mode press then coarse down press
        do_reset();
        mode = 1'b0;
        tick(1);  chk("t3_coarse", 32'(coarse), 32'd1);
        mode = 1'b1;
        tick(1);
        dn = 1'b0;
        tick(1);  chk("t3_down",  32'(value),  32'd112);
        chk("t3_dpulse", 32'(update), 32'd1);
        dn = 1'b1;
        tick(2);

        // 3b: coarse down held, saturating at MIN_VAL
        dn = 1'b0;
        tick(1);  chk("t3_96", 32'(value), 32'd96);
        tick(10); chk("t3_80", 32'(value), 32'd80);
        tick(4);  chk("t3_64", 32'(value), 32'd64);
        tick(4);  chk("t3_48", 32'(value), 32'd48);
        tick(4);  chk("t3_32", 32'(value), 32'd32);
        tick(4);  chk("t3_16", 32'(value), 32'd16);
        tick(4);  chk("t3_0",  32'(value), 32'd0);
        chk("t3_at_min", 32'(at_min), 32'd1);
        tick(4);  chk("t3_sat_min", 32'(value), 32'd0);
        chk("t3_sat_nopul", 32'(update), 32'd0);
        dn = 1'b1;
        tick(1);

        // 3c: mode and down in the same cycle use the pre-toggle fine step
        do_reset();
        mode = 1'b0; dn = 1'b0;
        tick(1);  chk("t3_pre_val", 32'(value),  32'd127);
        chk("t3_pre_coarse", 32'(coarse), 32'd1);
        mode = 1'b1; dn = 1'b1;
        tick(1);

        // 3d: second instance saturates at MAX_VAL
        up2 = 1'b0;
        tick(1);  chk("t3_251", 32'(value2), 32'd251);
        tick(10); chk("t3_252", 32'(value2), 32'd252);
        tick(4);  chk("t3_253", 32'(value2), 32'd253);
        tick(4);  chk("t3_254", 32'(value2), 32'd254);
        tick(4);  chk("t3_255", 32'(value2), 32'd255);
        chk("t3_at_max", 32'(at_max2), 32'd1);
        chk("t3_pul255", 32'(update2), 32'd1);
        tick(4);  chk("t3_sat_max", 32'(value2), 32'd255);
        chk("t3_sat_max_nopul", 32'(update2), 32'd0);
        up2 = 1'b1;
        tick(1);

        // 4: simultaneous press -> LOCK, then new down press
        do_reset();
        up = 1'b0; dn = 1'b0;
        tick(1);  chk("t4_lock",  32'(value), 32'd128);
        chk("t4_lock_pul", 32'(update), 32'd0);
        up = 1'b1;
        tick(3);  chk("t4_lockdn", 32'(value), 32'd128);
        dn = 1'b1;
        tick(1);
        dn = 1'b0;
        tick(1);  chk("t4_down", 32'(value), 32'd127);
        dn = 1'b1;
        tick(1);
        // opposite button during hold -> LOCK, no repeat
        up = 1'b0;
        tick(1);  chk("t4_hold", 32'(value), 32'd128);
        tick(2);
        dn = 1'b0;
        tick(1);  chk("t4_lock2", 32'(value), 32'd128);
        tick(12); chk("t4_lock2_hold", 32'(value), 32'd128);
        up = 1'b1; dn = 1'b1;
        tick(1);

        // 5: reset while in RPT_UP with up still held
        do_reset();
        up = 1'b0;
        tick(1);  chk("t5_129", 32'(value), 32'd129);
        tick(9);
        tick(1);  chk("t5_130", 32'(value), 32'd130);
        tick(2);
        rst = 1'b1;
        tick(1);  chk("t5_rst", 32'(value), 32'd128);
        chk("t5_rst_pul", 32'(update), 32'd0);
        rst = 1'b0;
        tick(1);  chk("t5_repress", 32'(value), 32'd129);
        chk("t5_repress_pul", 32'(update), 32'd1);
        up = 1'b1;
        tick(1);

        // 6: presses begun while disabled do not fire on enable
        do_reset();
        en = 1'b0; up = 1'b0; mode = 1'b0;
        tick(3);  chk("t6_dis_val", 32'(value),  32'd128);
        chk("t6_dis_coarse", 32'(coarse), 32'd0);
        en = 1'b1;
        tick(3);  chk("t6_en_val", 32'(value),  32'd128);
        chk("t6_en_coarse", 32'(coarse), 32'd0);
        up = 1'b1; mode = 1'b1;
        tick(1);
        up = 1'b0;
        tick(1);  chk("t6_press", 32'(value), 32'd129);
        up = 1'b1;
        tick(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_param_ctrl.md
Name: button_param_ctrl

Overview:
Sequencer that turns debounced push-button levels (active-low, released = 1) into controlled edits of one run-time parameter register, e.g. a phase or threshold setpoint for the resonant-converter hybrid controller. It provides edge detection, a hold-to-repeat state machine and a coarse/fine step toggle, and saturates the value at configurable bounds. It sits between the debounce instances on the board buttons and the control datapath that consumes o_value.

Parameters:
WIDTH, 8, bit width of o_value
INIT_VAL, 128, o_value after reset
MIN_VAL, 0, lower saturation bound (MIN_VAL <= INIT_VAL <= MAX_VAL)
MAX_VAL, 255, upper saturation bound
STEP_FINE, 1, step magnitude when o_coarse = 0
STEP_COARSE, 16, step magnitude when o_coarse = 1
HOLD_DELAY, 25000000, cycles a button must stay held after the first step before auto-repeat starts (>= 2)
REPEAT_PERIOD, 5000000, cycles between auto-repeat steps (>= 2)

Ports:
i_clk  input  1  system clock
i_reset  input  1  synchronous, active-high reset
i_enable  input  1  1 = buttons honoured; 0 = force IDLE and ignore presses
i_btn_up  input  1  debounced up button, active-low
i_btn_down  input  1  debounced down button, active-low
i_btn_mode  input  1  debounced mode button, active-low
o_value  output  WIDTH  current parameter value
o_coarse  output  1  current step mode (1 = coarse)
o_update  output  1  one-cycle pulse, asserted in the cycle o_value takes a new, different value
o_at_min  output  1  combinational: o_value == MIN_VAL
o_at_max  output  1  combinational: o_value == MAX_VAL

Behaviour:
- Reset (synchronous, i_reset = 1 at a clk edge): o_value = INIT_VAL, o_coarse = 0, o_update = 0, state = IDLE, counter = 0, the previous-sample registers of all three buttons = 1. Reset overrides any in-progress hold or repeat.
- Press event: previous sample = 1 and current sample = 0. A button held through reset therefore produces a press in the first cycle after reset.
- Step: the step value is STEP_COARSE when o_coarse = 1, otherwise STEP_FINE.
- Step arithmetic: computed in WIDTH+1 bits and clamped to [MIN_VAL, MAX_VAL]; it never wraps.
- o_update: if the clamped result equals the current o_value, there is no pulse and the state machine still advances normally.
- Latency: a step is registered at the clk edge that samples the triggering condition. o_value and o_update change together one cycle after the button sample.
- States: IDLE, HOLD_UP, HOLD_DN, RPT_UP, RPT_DN, LOCK.
  - IDLE: up press with down = 1 -> apply +step, counter = 0, go to HOLD_UP. Down press with up = 1 -> apply -step, go to HOLD_DN. Both buttons low in the same cycle -> go to LOCK with no step.
  - HOLD_x: counter increments each cycle while the button is held. When counter == HOLD_DELAY-1, apply the step, counter = 0, go to RPT_x.
  - RPT_x: counter increments. When counter == REPEAT_PERIOD-1, apply the step and set counter = 0.
  - HOLD_x / RPT_x, own button released (= 1): go to IDLE, counter = 0, no step that cycle. The release check has priority over a simultaneous terminal count.
  - HOLD_x / RPT_x, opposite button goes low: go to LOCK with no step.
  - LOCK: wait until both up and down = 1, then go to IDLE. A button still held on exit needs a new press to act.
- Mode button: a press toggles o_coarse in any state, independent of the up/down FSM. A step applied in the same cycle uses the pre-toggle o_coarse.
- i_enable = 0: the state machine goes to IDLE and counter = 0. o_value and o_coarse hold. Previous-sample registers keep tracking the buttons, so presses that began while disabled do not fire when i_enable rises.
- Counter width: clog2 of max(HOLD_DELAY, REPEAT_PERIOD) + 1 bits.

Test Plan:
Tests override HOLD_DELAY = 10 and REPEAT_PERIOD = 4; all other parameters stay at their defaults.
1. Reset, then a single 3-cycle up press -> o_value 128 -> 129 one cycle after the press sample, exactly one o_update pulse, state back to IDLE, no further change.
2. Up held for 30 cycles -> steps at press+1, +11, +15, +19, +23, +27; o_value = 134; six o_update pulses.
3. Mode press, then a down press -> o_coarse = 1, o_value 128 -> 112. Next, INIT_VAL = 250 with up held: values 251 -> 255, o_at_max = 1, no o_update on saturated steps.
4. Up and down pressed in the same cycle, then up released while down stays held -> no change while in LOCK; release both, then press down -> 127.
5. Up held in RPT_UP, then i_reset pulsed for 1 cycle while up stays held -> o_value = 128 after reset, then 129 on the first post-reset cycle (held-through-reset press rule).
6. i_enable = 0, up pressed and held, then i_enable = 1 -> no change until up is released and pressed again, then 129.
